// File: rtl/pong_pkg.sv
// pong_pkg
//   Shared definitions for the Pong game datapath: the game state encoding,
//   default screen/paddle geometry, the ball center position used by both the
//   game controller and the pixel color logic, and a wrap-free |a-b| helper.
//   No ports (package).

package pong_pkg;

    // Default geometry for a 640x480 VGA frame.
    localparam int H_ACTIVE_DEF        = 640;
    localparam int V_ACTIVE_DEF        = 480;
    localparam int PADDLE_HEIGHT_2_DEF = 30;

    // Ball serve/rest position; the pixel color logic uses the same point.
    localparam logic [9:0] CENTER_X = 10'(H_ACTIVE_DEF / 2);
    localparam logic [9:0] CENTER_Y = 10'(V_ACTIVE_DEF / 2);

    // Encoding is visible on o_State, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Distance between two unsigned coordinates: compare first, then
    // subtract the smaller from the larger so the result never wraps.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if
//   Bundles the frame tick, player controls and all registered game outputs
//   of pong_game_ctrl.
//   master : drives tick/start/paddle controls, observes game outputs
//   slave  : the game controller itself
//   Signals: i_Frame_Tick, i_Start, i_Left_Up, i_Left_Dn, i_Right_Up,
//            i_Right_Dn (inputs to the controller); o_Ball_X, o_Ball_Y,
//            o_Ball_Visible, o_Paddle_Left_Y, o_Paddle_Right_Y,
//            o_Left_Score, o_Right_Score, o_State, o_Update_Done (outputs).

interface pong_game_ctrl_if;

    logic       i_Frame_Tick;
    logic       i_Start;
    logic       i_Left_Up;
    logic       i_Left_Dn;
    logic       i_Right_Up;
    logic       i_Right_Dn;

    logic [9:0] o_Ball_X;
    logic [9:0] o_Ball_Y;
    logic       o_Ball_Visible;
    logic [9:0] o_Paddle_Left_Y;
    logic [9:0] o_Paddle_Right_Y;
    logic [3:0] o_Left_Score;
    logic [3:0] o_Right_Score;
    logic [2:0] o_State;
    logic       o_Update_Done;

    modport master (
        output i_Frame_Tick, i_Start, i_Left_Up, i_Left_Dn, i_Right_Up, i_Right_Dn,
        input  o_Ball_X, o_Ball_Y, o_Ball_Visible, o_Paddle_Left_Y, o_Paddle_Right_Y,
               o_Left_Score, o_Right_Score, o_State, o_Update_Done
    );

    modport slave (
        input  i_Frame_Tick, i_Start, i_Left_Up, i_Left_Dn, i_Right_Up, i_Right_Dn,
        output o_Ball_X, o_Ball_Y, o_Ball_Visible, o_Paddle_Left_Y, o_Paddle_Right_Y,
               o_Left_Score, o_Right_Score, o_State, o_Update_Done
    );

endinterface

// File: rtl/pong_paddle.sv
// pong_paddle
//   One paddle's vertical position. Moves PADDLE_STEP rows per enabled frame
//   tick and saturates so the paddle body never leaves the screen.
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous active-high reset (y returns to V_ACTIVE/2)
//     tick in   frame tick; the only cycle on which y may change
//     en   in   movement enable (low while the game is over)
//     up   in   move toward smaller y
//     dn   in   move toward larger y
//     y    out  paddle center row

module pong_paddle
    import pong_pkg::*;
#(
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int PADDLE_HEIGHT_2 = PADDLE_HEIGHT_2_DEF,
    parameter int PADDLE_STEP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       en,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] y
);

    localparam logic [9:0] Y_MIN  = 10'(PADDLE_HEIGHT_2);
    localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE - PADDLE_HEIGHT_2);
    localparam logic [9:0] STEP   = 10'(PADDLE_STEP);
    localparam logic [9:0] Y_INIT = 10'(V_ACTIVE / 2);

    logic [9:0] y_d;

    // NOTE: y_d gets its hold value before any branch, so every path assigns
    // it and no latch is inferred.
    always_comb begin
        y_d = y;
        if (tick && en) begin
            // Bounds are checked before the add/subtract so y never wraps.
            if (up && !dn) begin
                y_d = (y >= Y_MIN + STEP) ? (y - STEP) : Y_MIN;
            end else if (dn && !up) begin
                y_d = (y <= Y_MAX - STEP) ? (y + STEP) : Y_MAX;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= Y_INIT;
        end else begin
            y <= y_d;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//   Frame-synchronous Pong sequencer: ball motion and bounces, paddle hit
//   tests, scoring and the IDLE/SERVE/PLAY/POINT/OVER sequence. Everything
//   advances once per i_Frame_Tick and is registered, so positions are
//   stable during active video.
//   Ports:
//     i_Clk    in      system clock
//     i_Reset  in      synchronous active-high reset, wins over a tick
//     bus      slave   tick, start, paddle controls in; ball, paddles,
//                      scores, state and o_Update_Done out

module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int PADDLE_HEIGHT_2 = PADDLE_HEIGHT_2_DEF,
    parameter int PADDLE_STEP     = 2,
    parameter int SERVE_FRAMES    = 60,
    parameter int POINT_FRAMES    = 30,
    parameter int WIN_SCORE       = 9
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    pong_game_ctrl_if.slave  bus
);

    localparam logic [9:0] X_CTR      = 10'(H_ACTIVE / 2);
    localparam logic [9:0] Y_CTR      = 10'(V_ACTIVE / 2);
    localparam logic [9:0] X_MAX      = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_MAX      = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HALF_H     = 10'(PADDLE_HEIGHT_2);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] WIN_V      = 4'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] ball_x_q, ball_x_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic       visible_q, visible_d;
    logic       dx_neg_q, dx_neg_d;     // 1: ball moving toward x=0
    logic       dy_neg_q, dy_neg_d;     // 1: ball moving toward y=0
    logic [3:0] left_score_q, left_score_d;
    logic [3:0] right_score_q, right_score_d;
    logic       done_q;

    logic [9:0] left_y, right_y;
    logic       paddle_en;
    logic       left_hit, right_hit;
    logic       left_point, right_point;

    assign paddle_en = (state_q != ST_OVER);

    pong_paddle #(
        .V_ACTIVE       (V_ACTIVE),
        .PADDLE_HEIGHT_2(PADDLE_HEIGHT_2),
        .PADDLE_STEP    (PADDLE_STEP)
    ) u_left_paddle (
        .clk (i_Clk),
        .rst (i_Reset),
        .tick(bus.i_Frame_Tick),
        .en  (paddle_en),
        .up  (bus.i_Left_Up),
        .dn  (bus.i_Left_Dn),
        .y   (left_y)
    );

    pong_paddle #(
        .V_ACTIVE       (V_ACTIVE),
        .PADDLE_HEIGHT_2(PADDLE_HEIGHT_2),
        .PADDLE_STEP    (PADDLE_STEP)
    ) u_right_paddle (
        .clk (i_Clk),
        .rst (i_Reset),
        .tick(bus.i_Frame_Tick),
        .en  (paddle_en),
        .up  (bus.i_Right_Up),
        .dn  (bus.i_Right_Dn),
        .y   (right_y)
    );

    // Paddle registers still hold their pre-move value during the tick cycle,
    // so hit tests see the paddles as they were drawn in the last frame.
    assign left_hit  = (abs_diff(ball_y_q, left_y)  < HALF_H);
    assign right_hit = (abs_diff(ball_y_q, right_y) < HALF_H);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        visible_d     = visible_q;
        dx_neg_d      = dx_neg_q;
        dy_neg_d      = dy_neg_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        left_point    = 1'b0;
        right_point   = 1'b0;

        if (bus.i_Frame_Tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_Start) begin
                        state_d = ST_SERVE;
                        cnt_d   = '0;
                    end
                end

                ST_SERVE: begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                ST_PLAY: begin
                    // X axis: paddle at each edge either returns the ball or
                    // concedes a point.
                    if (ball_x_q == '0 && dx_neg_q) begin
                        if (left_hit) begin
                            ball_x_d = 10'd1;
                            dx_neg_d = 1'b0;
                        end else begin
                            right_point = 1'b1;
                        end
                    end else if (ball_x_q == X_MAX && !dx_neg_q) begin
                        if (right_hit) begin
                            ball_x_d = X_MAX - 10'd1;
                            dx_neg_d = 1'b1;
                        end else begin
                            left_point = 1'b1;
                        end
                    end else begin
                        ball_x_d = dx_neg_q ? (ball_x_q - 10'd1) : (ball_x_q + 10'd1);
                    end

                    // Y axis: top and bottom walls always reflect.
                    if (ball_y_q == '0 && dy_neg_q) begin
                        ball_y_d = 10'd1;
                        dy_neg_d = 1'b0;
                    end else if (ball_y_q == Y_MAX && !dy_neg_q) begin
                        ball_y_d = Y_MAX - 10'd1;
                        dy_neg_d = 1'b1;
                    end else begin
                        ball_y_d = dy_neg_q ? (ball_y_q - 10'd1) : (ball_y_q + 10'd1);
                    end

                    // A point recenters and hides the ball; the next serve
                    // heads toward the player who just lost.
                    if (left_point || right_point) begin
                        if (right_point) begin
                            right_score_d = right_score_q + 4'd1;
                            dx_neg_d      = 1'b1;
                        end else begin
                            left_score_d  = left_score_q + 4'd1;
                            dx_neg_d      = 1'b0;
                        end
                        ball_x_d  = X_CTR;
                        ball_y_d  = Y_CTR;
                        dy_neg_d  = 1'b0;
                        visible_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = (left_score_d == WIN_V || right_score_d == WIN_V)
                                    ? ST_OVER : ST_POINT;
                    end
                end

                ST_POINT: begin
                    if (cnt_q == POINT_LAST) begin
                        state_d   = ST_SERVE;
                        visible_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end

                ST_OVER: begin
                    if (bus.i_Start) begin
                        left_score_d  = '0;
                        right_score_d = '0;
                        visible_d     = 1'b1;
                        dx_neg_d      = 1'b0;
                        cnt_d         = '0;
                        state_d       = ST_SERVE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ball_x_q      <= X_CTR;
            ball_y_q      <= Y_CTR;
            visible_q     <= 1'b1;
            dx_neg_q      <= 1'b0;
            dy_neg_q      <= 1'b0;
            left_score_q  <= '0;
            right_score_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            visible_q     <= visible_d;
            dx_neg_q      <= dx_neg_d;
            dy_neg_q      <= dy_neg_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            done_q        <= bus.i_Frame_Tick;
        end
    end

    assign bus.o_Ball_X         = ball_x_q;
    assign bus.o_Ball_Y         = ball_y_q;
    assign bus.o_Ball_Visible   = visible_q;
    assign bus.o_Paddle_Left_Y  = left_y;
    assign bus.o_Paddle_Right_Y = right_y;
    assign bus.o_Left_Score     = left_score_q;
    assign bus.o_Right_Score    = right_score_q;
    assign bus.o_State          = state_q;
    assign bus.o_Update_Done    = done_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl
//   Self-checking bench for pong_game_ctrl. A behavioural game model predicts
//   every frame; each tick pushes the predicted outputs to a queue which is
//   popped and compared when o_Update_Done appears. Scenario tasks add direct
//   checks on the behaviours called out for the game (serve length, hits,
//   points, game over, paddle saturation, reset during play).

module tb_pong_game_ctrl;

    localparam int HA  = 640;
    localparam int VA  = 480;
    localparam int PH2 = 30;

    logic i_Clk = 1'b0;
    logic i_Reset;

    pong_game_ctrl_if bus();

    pong_game_ctrl dut (
        .i_Clk  (i_Clk),
        .i_Reset(i_Reset),
        .bus    (bus)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct packed {
        logic [9:0] ball_x;
        logic [9:0] ball_y;
        logic       vis;
        logic [9:0] lp;
        logic [9:0] rp;
        logic [3:0] ls;
        logic [3:0] rs;
        logic [2:0] st;
    } snap_t;

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    tick_no = 0;
    int    done_cnt = 0;

    // Game model state
    int m_x, m_y, m_dx, m_dy, m_vis, m_lp, m_rp, m_ls, m_rs, m_st, m_cnt;
    bit ev_left_hit, ev_right_hit, ev_left_pt, ev_right_pt;

    always @(posedge i_Clk) begin
        if (bus.o_Update_Done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic snap_t observe();
        snap_t s;
        s.ball_x = bus.o_Ball_X;
        s.ball_y = bus.o_Ball_Y;
        s.vis    = bus.o_Ball_Visible;
        s.lp     = bus.o_Paddle_Left_Y;
        s.rp     = bus.o_Paddle_Right_Y;
        s.ls     = bus.o_Left_Score;
        s.rs     = bus.o_Right_Score;
        s.st     = bus.o_State;
        return s;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s.ball_x = 10'd320;
        s.ball_y = 10'd240;
        s.vis    = 1'b1;
        s.lp     = 10'd240;
        s.rp     = 10'd240;
        s.ls     = 4'd0;
        s.rs     = 4'd0;
        s.st     = 3'd0;
        return s;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.ball_x = 10'(m_x);
        s.ball_y = 10'(m_y);
        s.vis    = 1'(m_vis);
        s.lp     = 10'(m_lp);
        s.rp     = 10'(m_rp);
        s.ls     = 4'(m_ls);
        s.rs     = 4'(m_rs);
        s.st     = 3'(m_st);
        return s;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_x = HA / 2; m_y = VA / 2; m_dx = 1; m_dy = 1; m_vis = 1;
        m_lp = VA / 2; m_rp = VA / 2; m_ls = 0; m_rs = 0; m_st = 0; m_cnt = 0;
    endtask

    function automatic int move_paddle(int p, logic up, logic dn);
        if (up && !dn) return (p - 2 < PH2) ? PH2 : p - 2;
        if (dn && !up) return (p + 2 > VA - PH2) ? VA - PH2 : p + 2;
        return p;
    endfunction

    task automatic model_step();
        int old_lp, old_rp, pt;
        bit en;
        old_lp = m_lp; old_rp = m_rp;
        en = (m_st != 4);
        ev_left_hit = 0; ev_right_hit = 0; ev_left_pt = 0; ev_right_pt = 0;
        case (m_st)
            0: if (bus.i_Start) begin m_st = 1; m_cnt = 0; end
            1: if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end else m_cnt++;
            2: begin
                pt = 0;
                if (m_x == 0 && m_dx < 0) begin
                    if (iabs(m_y - old_lp) < PH2) begin m_x = 1; m_dx = 1; ev_left_hit = 1; end
                    else pt = 2;
                end else if (m_x == HA - 1 && m_dx > 0) begin
                    if (iabs(m_y - old_rp) < PH2) begin m_x = HA - 2; m_dx = -1; ev_right_hit = 1; end
                    else pt = 1;
                end else begin
                    m_x += m_dx;
                end
                if (m_y == 0 && m_dy < 0) begin m_y = 1; m_dy = 1; end
                else if (m_y == VA - 1 && m_dy > 0) begin m_y = VA - 2; m_dy = -1; end
                else m_y += m_dy;
                if (pt != 0) begin
                    if (pt == 2) begin m_rs++; m_dx = -1; ev_right_pt = 1; end
                    else begin m_ls++; m_dx = 1; ev_left_pt = 1; end
                    m_vis = 0; m_cnt = 0; m_x = HA / 2; m_y = VA / 2; m_dy = 1;
                    m_st = (m_rs == 9 || m_ls == 9) ? 4 : 3;
                end
            end
            3: if (m_cnt == 29) begin m_st = 1; m_vis = 1; m_cnt = 0; end else m_cnt++;
            4: if (bus.i_Start) begin m_ls = 0; m_rs = 0; m_vis = 1; m_dx = 1; m_st = 1; m_cnt = 0; end
            default: ;
        endcase
        if (en) begin
            m_lp = move_paddle(old_lp, bus.i_Left_Up, bus.i_Left_Dn);
            m_rp = move_paddle(old_rp, bus.i_Right_Up, bus.i_Right_Dn);
        end
    endtask

    // One frame: pulse the tick, predict, wait for o_Update_Done, compare.
    task automatic do_tick();
        snap_t e, o;
        int w;
        tick_no++;
        bus.i_Frame_Tick = 1'b1;
        model_step();
        exp_q.push_back(model_snap());
        @(posedge i_Clk); #1;
        bus.i_Frame_Tick = 1'b0;
        w = 0;
        while (bus.o_Update_Done !== 1'b1 && w < 4) begin
            @(posedge i_Clk); #1;
            w++;
        end
        checks++;
        if (bus.o_Update_Done !== 1'b1) begin
            errors++;
            $display("FAIL update_done tick=%0d: got %b want 1", tick_no, bus.o_Update_Done);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            o = observe();
            if (o !== e) begin
                errors++;
                $display("FAIL frame_outputs tick=%0d got x=%0d y=%0d vis=%0b lp=%0d rp=%0d ls=%0d rs=%0d st=%0d want x=%0d y=%0d vis=%0b lp=%0d rp=%0d ls=%0d rs=%0d st=%0d",
                         tick_no, o.ball_x, o.ball_y, o.vis, o.lp, o.rp, o.ls, o.rs, o.st,
                         e.ball_x, e.ball_y, e.vis, e.lp, e.rp, e.ls, e.rs, e.st);
            end
        end
        repeat (7) @(posedge i_Clk);
        #1;
    endtask

    function automatic int predict_y(int y0, int dy0, int n);
        int y, dy;
        y = y0; dy = dy0;
        for (int i = 0; i < n; i++) begin
            if (y == 0 && dy < 0) begin y = 1; dy = 1; end
            else if (y == VA - 1 && dy > 0) begin y = VA - 2; dy = -1; end
            else y += dy;
        end
        return y;
    endfunction

    // mode 1: line up with the predicted arrival row; mode 2: stay far away.
    function automatic int aim(int pred, int mode);
        if (mode == 1) return (pred < PH2) ? PH2 : (pred > VA - PH2) ? VA - PH2 : pred;
        if (mode == 2) return (pred >= VA / 2) ? PH2 : VA - PH2;
        return VA / 2;
    endfunction

    task automatic steer(input int lmode, input int rmode);
        int lt, rt;
        lt = VA / 2; rt = VA / 2;
        if (m_st == 2 && m_dx < 0) lt = aim(predict_y(m_y, m_dy, m_x), lmode);
        if (m_st == 2 && m_dx > 0) rt = aim(predict_y(m_y, m_dy, HA - 1 - m_x), rmode);
        bus.i_Left_Dn  = (m_lp < lt - 1);
        bus.i_Left_Up  = (m_lp > lt + 1);
        bus.i_Right_Dn = (m_rp < rt - 1);
        bus.i_Right_Up = (m_rp > rt + 1);
    endtask

    task automatic clear_inputs();
        bus.i_Frame_Tick = 1'b0;
        bus.i_Start      = 1'b0;
        bus.i_Left_Up    = 1'b0;
        bus.i_Left_Dn    = 1'b0;
        bus.i_Right_Up   = 1'b0;
        bus.i_Right_Dn   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_Reset = 1'b1;
        repeat (2) @(posedge i_Clk);
        #1;
        i_Reset = 1'b0;
        model_reset();
        exp_q.delete();
        checks++;
        if (observe() !== reset_snap()) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", observe(), reset_snap());
        end
        checks++;
        if (bus.o_Update_Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", bus.o_Update_Done);
        end
    endtask

    task automatic test_idle();
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < 5; i++) do_tick();
        checks++;
        if (done_cnt - c0 !== 5) begin
            errors++;
            $display("FAIL idle_done_pulses: got %0d want 5", done_cnt - c0);
        end
        checks++;
        if (bus.o_State !== 3'd0 || bus.o_Ball_X !== 10'd320 || bus.o_Ball_Y !== 10'd240) begin
            errors++;
            $display("FAIL idle_hold: got st=%0d x=%0d y=%0d want 0 320 240",
                     bus.o_State, bus.o_Ball_X, bus.o_Ball_Y);
        end
    endtask

    task automatic test_paddles();
        bus.i_Left_Up = 1'b1;
        bus.i_Right_Dn = 1'b1;
        for (int i = 0; i < 104; i++) do_tick();
        checks++;
        if (bus.o_Paddle_Left_Y !== 10'd32 || bus.o_Paddle_Right_Y !== 10'd448) begin
            errors++;
            $display("FAIL paddle_travel: got l=%0d r=%0d want 32 448",
                     bus.o_Paddle_Left_Y, bus.o_Paddle_Right_Y);
        end
        for (int i = 0; i < 3; i++) begin
            do_tick();
            checks++;
            if (bus.o_Paddle_Left_Y !== 10'd30 || bus.o_Paddle_Right_Y !== 10'd450) begin
                errors++;
                $display("FAIL paddle_saturate step=%0d: got l=%0d r=%0d want 30 450",
                         i, bus.o_Paddle_Left_Y, bus.o_Paddle_Right_Y);
            end
        end
        bus.i_Left_Dn = 1'b1;
        bus.i_Right_Up = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_tick();
            checks++;
            if (bus.o_Paddle_Left_Y !== 10'd30 || bus.o_Paddle_Right_Y !== 10'd450) begin
                errors++;
                $display("FAIL paddle_both_hold: got l=%0d r=%0d want 30 450",
                         bus.o_Paddle_Left_Y, bus.o_Paddle_Right_Y);
            end
        end
        clear_inputs();
    endtask

    task automatic test_serve();
        int n_serve;
        bus.i_Start = 1'b1;
        do_tick();
        bus.i_Start = 1'b0;
        n_serve = 0;
        while (bus.o_State === 3'd1 && n_serve < 100) begin
            n_serve++;
            do_tick();
        end
        checks++;
        if (n_serve !== 60 || bus.o_State !== 3'd2) begin
            errors++;
            $display("FAIL serve_length: got %0d frames then st=%0d want 60 then 2", n_serve, bus.o_State);
        end
        do_tick();
        checks++;
        if (bus.o_Ball_X !== 10'd321 || bus.o_Ball_Y !== 10'd241) begin
            errors++;
            $display("FAIL first_play_move: got (%0d,%0d) want (321,241)", bus.o_Ball_X, bus.o_Ball_Y);
        end
    endtask

    task automatic test_hits();
        int n;
        bit got_l, got_r;
        logic [3:0] ls0, rs0;
        got_l = 0; got_r = 0; n = 0;
        while (!(got_l && got_r) && n < 3000) begin
            steer(1, 1);
            ls0 = bus.o_Left_Score;
            rs0 = bus.o_Right_Score;
            do_tick();
            n++;
            if (ev_left_hit) begin
                got_l = 1;
                checks++;
                if (bus.o_Ball_X !== 10'd1 || bus.o_Left_Score !== ls0 || bus.o_Right_Score !== rs0) begin
                    errors++;
                    $display("FAIL left_hit: got x=%0d ls=%0d rs=%0d want x=1 ls=%0d rs=%0d",
                             bus.o_Ball_X, bus.o_Left_Score, bus.o_Right_Score, ls0, rs0);
                end
            end
            if (ev_right_hit) begin
                got_r = 1;
                checks++;
                if (bus.o_Ball_X !== 10'd638 || bus.o_Left_Score !== ls0 || bus.o_Right_Score !== rs0) begin
                    errors++;
                    $display("FAIL right_hit: got x=%0d ls=%0d rs=%0d want x=638 ls=%0d rs=%0d",
                             bus.o_Ball_X, bus.o_Left_Score, bus.o_Right_Score, ls0, rs0);
                end
            end
        end
        checks++;
        if (!(got_l && got_r)) begin
            errors++;
            $display("FAIL hit_events: got left=%0b right=%0b want both", got_l, got_r);
        end
    endtask

    task automatic test_point();
        int n, k;
        logic [3:0] rs0;
        n = 0;
        rs0 = bus.o_Right_Score;
        ev_left_pt = 0; ev_right_pt = 0;
        while (!(ev_left_pt || ev_right_pt) && n < 3000) begin
            steer(2, 1);
            rs0 = bus.o_Right_Score;
            do_tick();
            n++;
        end
        checks++;
        if (!ev_right_pt || bus.o_Right_Score !== rs0 + 4'd1 || bus.o_State !== 3'd3 || bus.o_Ball_Visible !== 1'b0) begin
            errors++;
            $display("FAIL right_point: got rs=%0d st=%0d vis=%0b want rs=%0d st=3 vis=0",
                     bus.o_Right_Score, bus.o_State, bus.o_Ball_Visible, rs0 + 4'd1);
        end
        k = 0;
        while (bus.o_State === 3'd3 && k < 100) begin
            steer(2, 1);
            do_tick();
            k++;
        end
        checks++;
        if (k !== 30 || bus.o_State !== 3'd1 || bus.o_Ball_Visible !== 1'b1) begin
            errors++;
            $display("FAIL point_length: got %0d frames then st=%0d vis=%0b want 30 then st=1 vis=1",
                     k, bus.o_State, bus.o_Ball_Visible);
        end
        k = 0;
        while (bus.o_State === 3'd1 && k < 100) begin
            steer(2, 1);
            do_tick();
            k++;
        end
        steer(2, 1);
        do_tick();
        checks++;
        if (bus.o_Ball_X !== 10'd319 || bus.o_Ball_Y !== 10'd241) begin
            errors++;
            $display("FAIL serve_toward_loser: got (%0d,%0d) want (319,241)", bus.o_Ball_X, bus.o_Ball_Y);
        end
    endtask

    task automatic test_game_over();
        int n;
        logic [9:0] lp0, rp0;
        n = 0;
        while (m_st != 4 && n < 6000) begin
            steer(2, 1);
            do_tick();
            n++;
        end
        checks++;
        if (bus.o_State !== 3'd4 || bus.o_Right_Score !== 4'd9 || bus.o_Ball_Visible !== 1'b0) begin
            errors++;
            $display("FAIL game_over: got st=%0d rs=%0d vis=%0b want st=4 rs=9 vis=0",
                     bus.o_State, bus.o_Right_Score, bus.o_Ball_Visible);
        end
        lp0 = bus.o_Paddle_Left_Y;
        rp0 = bus.o_Paddle_Right_Y;
        clear_inputs();
        if (lp0 < 10'd240) bus.i_Left_Dn = 1'b1; else bus.i_Left_Up = 1'b1;
        if (rp0 < 10'd240) bus.i_Right_Dn = 1'b1; else bus.i_Right_Up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_tick();
            checks++;
            if (bus.o_Paddle_Left_Y !== lp0 || bus.o_Paddle_Right_Y !== rp0) begin
                errors++;
                $display("FAIL over_paddles_frozen: got l=%0d r=%0d want %0d %0d",
                         bus.o_Paddle_Left_Y, bus.o_Paddle_Right_Y, lp0, rp0);
            end
        end
        clear_inputs();
        bus.i_Start = 1'b1;
        do_tick();
        bus.i_Start = 1'b0;
        checks++;
        if (bus.o_Left_Score !== 4'd0 || bus.o_Right_Score !== 4'd0 || bus.o_State !== 3'd1 || bus.o_Ball_Visible !== 1'b1) begin
            errors++;
            $display("FAIL restart: got ls=%0d rs=%0d st=%0d vis=%0b want 0 0 1 1",
                     bus.o_Left_Score, bus.o_Right_Score, bus.o_State, bus.o_Ball_Visible);
        end
    endtask

    task automatic test_reset_mid_play();
        int n;
        clear_inputs();
        n = 0;
        while (m_st != 2 && n < 200) begin
            do_tick();
            n++;
        end
        for (int i = 0; i < 3; i++) do_tick();
        checks++;
        if (bus.o_State !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_state: got %0d want 2", bus.o_State);
        end
        i_Reset = 1'b1;
        bus.i_Frame_Tick = 1'b1;
        @(posedge i_Clk); #1;
        i_Reset = 1'b0;
        bus.i_Frame_Tick = 1'b0;
        model_reset();
        exp_q.delete();
        checks++;
        if (observe() !== reset_snap()) begin
            errors++;
            $display("FAIL reset_mid_play: got %h want %h", observe(), reset_snap());
        end
        checks++;
        if (bus.o_Update_Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick_done: got %b want 0", bus.o_Update_Done);
        end
    endtask

    initial begin
        i_Reset = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_idle();
        test_paddles();
        test_reset();
        test_serve();
        test_hits();
        test_point();
        test_game_over();
        test_reset_mid_play();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
